// File: rtl/msp430_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : msp430_pkg
//  Description : Shared constants and types for the MSP430 PC sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package msp430_pkg;

   // Next-PC select codes driven by the control unit
   localparam logic [2:0] MPC_HOLD   = 3'd0;
   localparam logic [2:0] MPC_INC2   = 3'd1;
   localparam logic [2:0] MPC_CALC   = 3'd2;
   localparam logic [2:0] MPC_MDB_SH = 3'd3;
   localparam logic [2:0] MPC_MDB    = 3'd4;
   localparam logic [2:0] MPC_INC4   = 3'd5;
   localparam logic [2:0] MPC_JMP    = 3'd6;
   localparam logic [2:0] MPC_RSVD   = 3'd7;

   localparam logic [15:0] DEF_RESET_VECTOR = 16'hFFFE;

   typedef enum logic [1:0] {
      ST_RST_FETCH = 2'd0,
      ST_RUN       = 2'd1,
      ST_INT_FETCH = 2'd2
   } pc_state_t;

endpackage : msp430_pkg
`default_nettype wire

// File: rtl/pc_next_sel.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_sel
//  Description : Combinational next-PC selector with relative-jump adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_next_sel
   import msp430_pkg::*;
#(
   parameter int W         = 16,
   parameter int JMP_OFF_W = 10
) (
   input  logic [2:0]           mpc,
   input  logic [W-1:0]         pc,
   input  logic [W-1:0]         mdb_out,
   input  logic [W-1:0]         calc_out,
   input  logic [JMP_OFF_W-1:0] jmp_off,
   output logic [W-1:0]         next_pc,
   output logic                 rsvd
);

   logic [W-1:0] w_jmp_ext;
   logic [W-1:0] w_jmp_byte;
   logic [W-1:0] w_sel;

   // Word offset -> byte offset; all arithmetic wraps modulo 2^W
   assign w_jmp_ext  = W'($signed(jmp_off));
   assign w_jmp_byte = {w_jmp_ext[W-2:0], 1'b0};

   always_comb begin
      w_sel = pc;
      rsvd  = 1'b0;
      case (mpc)
         MPC_HOLD:   w_sel = pc;
         MPC_INC2:   w_sel = pc + W'(2);
         MPC_CALC:   w_sel = calc_out;
         MPC_MDB_SH: w_sel = {mdb_out[W-2:0], 1'b0};
         MPC_MDB:    w_sel = mdb_out;
         MPC_INC4:   w_sel = pc + W'(4);
         MPC_JMP:    w_sel = pc + W'(2) + w_jmp_byte;
         MPC_RSVD:   rsvd  = 1'b1;
         default:    rsvd  = 1'b1;
      endcase
   end

   assign next_pc = w_sel & ~W'(1);

endmodule : pc_next_sel
`default_nettype wire

// File: rtl/pc_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_seq_unit
//  Description : Registered PC sequencer with reset/interrupt vector fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_seq_unit
   import msp430_pkg::*;
#(
   parameter int             W            = 16,
   parameter logic [W-1:0]   RESET_VECTOR = W'(DEF_RESET_VECTOR),
   parameter int             JMP_OFF_W    = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [2:0]           MPC,
   input  logic                 pc_en,
   input  logic [W-1:0]         MDB_out,
   input  logic [W-1:0]         CALC_out,
   input  logic [JMP_OFF_W-1:0] jmp_off,
   input  logic                 irq,
   input  logic [W-1:0]         irq_vec_addr,
   output logic                 vec_req,
   output logic [W-1:0]         vec_addr,
   input  logic                 vec_ack,
   input  logic [W-1:0]         vec_data,
   output logic [W-1:0]         reg_PC_out,
   output logic                 busy,
   output logic                 irq_taken,
   output logic                 sel_err
);

   pc_state_t    r_state,     w_state_nxt;
   logic [W-1:0] r_pc,        w_pc_nxt;
   logic         r_vec_req,   w_vec_req_nxt;
   logic [W-1:0] r_vec_addr,  w_vec_addr_nxt;
   logic         r_busy,      w_busy_nxt;
   logic         r_irq_taken, w_irq_taken_nxt;
   logic         r_sel_err,   w_sel_err_nxt;

   logic [W-1:0] w_sel_pc;
   logic         w_sel_rsvd;

   pc_next_sel #(
      .W         (W),
      .JMP_OFF_W (JMP_OFF_W)
   ) u_next_sel (
      .mpc      (MPC),
      .pc       (r_pc),
      .mdb_out  (MDB_out),
      .calc_out (CALC_out),
      .jmp_off  (jmp_off),
      .next_pc  (w_sel_pc),
      .rsvd     (w_sel_rsvd)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_vec_req_nxt   = r_vec_req;
      w_vec_addr_nxt  = r_vec_addr;
      w_busy_nxt      = r_busy;
      w_irq_taken_nxt = 1'b0;
      w_sel_err_nxt   = r_sel_err;

      case (r_state)
         ST_RST_FETCH, ST_INT_FETCH: begin
            // An ack only counts once the request is actually on the bus
            if (r_vec_req && vec_ack) begin
               w_pc_nxt        = vec_data & ~W'(1);
               w_vec_req_nxt   = 1'b0;
               w_busy_nxt      = 1'b0;
               w_irq_taken_nxt = (r_state == ST_INT_FETCH);
               w_state_nxt     = ST_RUN;
            end else begin
               w_vec_req_nxt = 1'b1;
               w_busy_nxt    = 1'b1;
            end
         end
         ST_RUN: begin
            if (irq) begin
               w_vec_addr_nxt = irq_vec_addr;
               w_vec_req_nxt  = 1'b1;
               w_busy_nxt     = 1'b1;
               w_state_nxt    = ST_INT_FETCH;
            end else if (pc_en) begin
               w_pc_nxt = w_sel_pc;
               if (w_sel_rsvd) begin
                  w_sel_err_nxt = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_RST_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_RST_FETCH;
         r_pc        <= '0;
         r_vec_req   <= 1'b0;
         r_vec_addr  <= RESET_VECTOR;
         r_busy      <= 1'b1;
         r_irq_taken <= 1'b0;
         r_sel_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_vec_req   <= w_vec_req_nxt;
         r_vec_addr  <= w_vec_addr_nxt;
         r_busy      <= w_busy_nxt;
         r_irq_taken <= w_irq_taken_nxt;
         r_sel_err   <= w_sel_err_nxt;
      end
   end

   assign reg_PC_out = r_pc;
   assign vec_req    = r_vec_req;
   assign vec_addr   = r_vec_addr;
   assign busy       = r_busy;
   assign irq_taken  = r_irq_taken;
   assign sel_err    = r_sel_err;

endmodule : pc_seq_unit
`default_nettype wire

// File: tb/tb_pc_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_seq_unit
//  Description : Self-checking bench for pc_seq_unit with a PC scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_seq_unit;

   logic        clk;
   logic        rst_n;
   logic [2:0]  MPC;
   logic        pc_en;
   logic [15:0] MDB_out;
   logic [15:0] CALC_out;
   logic [9:0]  jmp_off;
   logic        irq;
   logic [15:0] irq_vec_addr;
   logic        vec_req;
   logic [15:0] vec_addr;
   logic        vec_ack;
   logic [15:0] vec_data;
   logic [15:0] reg_PC_out;
   logic        busy;
   logic        irq_taken;
   logic        sel_err;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       tag;
      logic [15:0] pc;
   } exp_t;

   exp_t exp_q[$];

   pc_seq_unit #(
      .W            (16),
      .RESET_VECTOR (16'hFFFE),
      .JMP_OFF_W    (10)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .MPC          (MPC),
      .pc_en        (pc_en),
      .MDB_out      (MDB_out),
      .CALC_out     (CALC_out),
      .jmp_off      (jmp_off),
      .irq          (irq),
      .irq_vec_addr (irq_vec_addr),
      .vec_req      (vec_req),
      .vec_addr     (vec_addr),
      .vec_ack      (vec_ack),
      .vec_data     (vec_data),
      .reg_PC_out   (reg_PC_out),
      .busy         (busy),
      .irq_taken    (irq_taken),
      .sel_err      (sel_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_pop_check();
      exp_t e;
      if (exp_q.size() == 0) begin
         check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         check_eq(e.tag, {16'h0, reg_PC_out}, {16'h0, e.pc});
      end
   endtask

   // One pc_en cycle with the given select; expected PC queued at drive time
   task automatic drive_pc(input string tag, input logic [2:0] mpc_i, input logic [15:0] exp_pc);
      MPC   = mpc_i;
      pc_en = 1'b1;
      exp_q.push_back('{tag, exp_pc});
      tick();
      pc_en = 1'b0;
      sb_pop_check();
   endtask

   initial begin
      rst_n        = 1'b0;
      MPC          = 3'd0;
      pc_en        = 1'b0;
      MDB_out      = 16'h0;
      CALC_out     = 16'h0;
      jmp_off      = 10'h0;
      irq          = 1'b0;
      irq_vec_addr = 16'h0;
      vec_ack      = 1'b0;
      vec_data     = 16'h0;

      #12;
      check_eq("rst_pc",        {16'h0, reg_PC_out}, 32'h0);
      check_eq("rst_vec_req",   32'(vec_req),   32'd0);
      check_eq("rst_vec_addr",  {16'h0, vec_addr}, 32'hFFFE);
      check_eq("rst_busy",      32'(busy),      32'd1);
      check_eq("rst_irq_taken", 32'(irq_taken), 32'd0);
      check_eq("rst_sel_err",   32'(sel_err),   32'd0);

      // Reset release, request stays up three cycles before the ack edge
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("rf_vec_req",  32'(vec_req), 32'd1);
         check_eq("rf_vec_addr", {16'h0, vec_addr}, 32'hFFFE);
         check_eq("rf_busy",     32'(busy), 32'd1);
      end
      vec_ack  = 1'b1;
      vec_data = 16'hC001;
      exp_q.push_back('{"rf_pc", 16'hC000});
      tick();
      vec_ack = 1'b0;
      sb_pop_check();
      check_eq("rf_busy_done", 32'(busy), 32'd0);
      check_eq("rf_req_done",  32'(vec_req), 32'd0);
      check_eq("rf_no_irq_tk", 32'(irq_taken), 32'd0);

      // Next-PC selections
      MDB_out = 16'hFFFE;
      drive_pc("mdb_fffe", 3'd4, 16'hFFFE);
      drive_pc("inc2_wrap", 3'd1, 16'h0000);
      CALC_out = 16'h0100;
      drive_pc("calc", 3'd2, 16'h0100);
      jmp_off = 10'h3FF;
      drive_pc("jmp_m1", 3'd6, 16'h0100);
      jmp_off = 10'h005;
      drive_pc("jmp_p5", 3'd6, 16'h010C);
      MDB_out = 16'h1235;
      drive_pc("mdb_sh", 3'd3, 16'h246A);
      drive_pc("mdb_bit0", 3'd4, 16'h1234);
      drive_pc("inc4", 3'd5, 16'h1238);
      drive_pc("hold", 3'd0, 16'h1238);
      CALC_out = 16'h0101;
      drive_pc("calc_bit0", 3'd2, 16'h0100);
      jmp_off = 10'h200;
      drive_pc("jmp_wrap", 3'd6, 16'hFD02);
      check_eq("sel_err_clear", 32'(sel_err), 32'd0);
      drive_pc("rsvd_hold", 3'd7, 16'hFD02);
      check_eq("sel_err_set", 32'(sel_err), 32'd1);
      drive_pc("inc2_after", 3'd1, 16'hFD04);
      check_eq("sel_err_sticky", 32'(sel_err), 32'd1);

      MPC = 3'd1;
      exp_q.push_back('{"pc_en_low", 16'hFD04});
      tick();
      sb_pop_check();

      // Interrupt beats a same-cycle increment
      irq          = 1'b1;
      irq_vec_addr = 16'hFFF2;
      pc_en        = 1'b1;
      MPC          = 3'd1;
      exp_q.push_back('{"irq_no_inc", 16'hFD04});
      tick();
      sb_pop_check();
      check_eq("irq_vec_req",  32'(vec_req), 32'd1);
      check_eq("irq_vec_addr", {16'h0, vec_addr}, 32'hFFF2);
      check_eq("irq_busy",     32'(busy), 32'd1);
      irq_vec_addr = 16'h1111;
      exp_q.push_back('{"irq_busy_hold", 16'hFD04});
      tick();
      sb_pop_check();
      check_eq("irq_addr_stable", {16'h0, vec_addr}, 32'hFFF2);
      pc_en    = 1'b0;
      irq      = 1'b0;
      vec_ack  = 1'b1;
      vec_data = 16'h8000;
      exp_q.push_back('{"irq_pc", 16'h8000});
      tick();
      vec_ack = 1'b0;
      sb_pop_check();
      check_eq("irq_taken_pulse", 32'(irq_taken), 32'd1);
      check_eq("irq_busy_done",   32'(busy), 32'd0);
      tick();
      check_eq("irq_taken_end", 32'(irq_taken), 32'd0);

      // Shortest interrupt fetch: ack during the request's first cycle
      irq          = 1'b1;
      irq_vec_addr = 16'hFFF0;
      tick();
      irq      = 1'b0;
      vec_ack  = 1'b1;
      vec_data = 16'hA003;
      exp_q.push_back('{"irq_fast_pc", 16'hA002});
      tick();
      vec_ack = 1'b0;
      sb_pop_check();
      check_eq("irq_fast_taken", 32'(irq_taken), 32'd1);

      // Reset during an interrupt fetch
      irq          = 1'b1;
      irq_vec_addr = 16'hFFF4;
      tick();
      irq = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_pc",      {16'h0, reg_PC_out}, 32'h0);
      check_eq("mid_rst_vec_req", 32'(vec_req), 32'd0);
      check_eq("mid_rst_busy",    32'(busy), 32'd1);
      check_eq("mid_rst_sel_err", 32'(sel_err), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      check_eq("rrf_vec_req",  32'(vec_req), 32'd1);
      check_eq("rrf_vec_addr", {16'h0, vec_addr}, 32'hFFFE);
      vec_ack  = 1'b1;
      vec_data = 16'h4000;
      exp_q.push_back('{"rrf_pc", 16'h4000});
      tick();
      vec_ack = 1'b0;
      sb_pop_check();
      check_eq("rrf_no_irq_tk", 32'(irq_taken), 32'd0);

      // Stray ack in RUN is ignored
      vec_ack  = 1'b1;
      vec_data = 16'h1111;
      pc_en    = 1'b0;
      exp_q.push_back('{"stray_ack", 16'h4000});
      tick();
      vec_ack = 1'b0;
      sb_pop_check();
      check_eq("stray_busy",    32'(busy), 32'd0);
      check_eq("stray_vec_req", 32'(vec_req), 32'd0);
      drive_pc("stray_run", 3'd1, 16'h4002);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_pc_seq_unit
`default_nettype wire

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
Registered program-counter sequencer for the MSP430 core datapath; successor to the combinational PC source mux.
- Holds the PC register and selects the next PC from the same source set, plus a relative-jump adder.
- Adds width/vector parameters and a vector-fetch state machine: PC load from the reset vector after reset, and from an interrupt vector on request.
- Sits between the control unit (MPC, pc_en), the memory data bus (MDB) and the register file PC slot.

Parameters:
W, 16, PC/data width in bits (even, >= 8)
RESET_VECTOR, 16'hFFFE, address fetched after reset release (W bits)
JMP_OFF_W, 10, signed word-offset width for relative jumps

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
MPC  input  3  next-PC select code
pc_en  input  1  apply MPC selection this cycle
MDB_out  input  W  memory data bus read value
CALC_out  input  W  ALU/address calculator result
jmp_off  input  JMP_OFF_W  signed word offset for relative jump
irq  input  1  interrupt request, level
irq_vec_addr  input  W  vector address for pending interrupt
vec_req  output  1  vector read request to memory
vec_addr  output  W  vector address being read
vec_ack  input  1  memory returns vec_data this cycle
vec_data  input  W  vector contents
reg_PC_out  output  W  current PC (registered)
busy  output  1  vector fetch in progress; control unit must stall
irq_taken  output  1  one-cycle pulse when interrupt vector loaded
sel_err  output  1  sticky: reserved MPC code used

Behaviour:
- Reset (rst_n low, asynchronous): reg_PC_out=0, vec_req=0, vec_addr=RESET_VECTOR, busy=1, irq_taken=0, sel_err=0, state=RST_FETCH.
- States: RST_FETCH, RUN, INT_FETCH.
- RST_FETCH:
  - vec_req=1 from the first clock after rst_n release; vec_addr=RESET_VECTOR.
  - On a clock edge with vec_ack=1: PC <= {vec_data[W-1:1],0}, vec_req<=0, busy<=0, state<=RUN.
- RUN: at each edge with pc_en=1, PC <= sel, bit 0 always forced 0. sel by MPC:
  - 0: PC (hold)
  - 1: PC+2
  - 2: CALC_out
  - 3: MDB_out<<1
  - 4: MDB_out
  - 5: PC+4 (skip extension word)
  - 6: PC+2+(sign_extend(jmp_off)<<1)
  - 7: reserved; PC held, sel_err<=1 (cleared only by reset).
- pc_en=0 in RUN: PC held.
- All adds are modulo 2^W: 0xFFFE+2 -> 0x0000; backward jumps wrap below 0.
- irq=1 in RUN:
  - Takes priority over pc_en/MPC that cycle; PC held.
  - vec_addr<=irq_vec_addr (captured), vec_req<=1, busy<=1, state<=INT_FETCH.
- INT_FETCH:
  - On vec_ack: PC <= {vec_data[W-1:1],0}, irq_taken pulses 1 for one cycle, vec_req<=0, busy<=0, state<=RUN.
  - irq ignored until back in RUN.
- Handshake:
  - vec_req held high until ack; vec_addr stable while vec_req=1.
  - vec_ack with vec_req=0 ignored.
  - Ack latency is unbounded; ack in the same cycle req first rises is legal and completes the fetch at that edge.
- While busy=1: pc_en/MPC ignored, sel_err not updated.
- Latency: selection visible on reg_PC_out one cycle after the pc_en edge. A vector fetch occupies at least 2 cycles (req cycle, ack edge).
- Reset mid-fetch: all state cleared immediately; fetch restarts at RESET_VECTOR after release; pending irq dropped.

Decomposition:
- Shared package msp430_pkg:
  - MPC code constants (MPC_HOLD, MPC_INC2, MPC_CALC, MPC_MDB_SH, MPC_MDB, MPC_INC4, MPC_JMP, MPC_RSVD)
  - state encoding constants
  - default RESET_VECTOR
- Sub-module pc_next_sel: combinational next-PC selector/adder (MPC, PC, MDB_out, CALC_out, jmp_off -> next PC, rsvd flag).
- pc_seq_unit: registers, FSM and handshake.

Test Plan:
- Reset release, vec_ack after 3 cycles with vec_data=16'hC001 -> vec_req high for 3 cycles at vec_addr=16'hFFFE; PC=16'hC000, busy=0.
- RUN, PC=16'hFFFE, MPC=1, pc_en=1 -> PC=16'h0000. MPC=6, jmp_off=10'h3FF from PC=16'h0100 -> PC=16'h0100. jmp_off=10'h005 -> PC=16'h010C.
- MPC=3, MDB_out=16'h1235 -> PC=16'h246A. MPC=4 with same data -> PC=16'h1234. MPC=7 -> PC unchanged, sel_err=1 and stays 1.
- irq=1 with pc_en=1/MPC=1 same cycle, irq_vec_addr=16'hFFF2, ack with 16'h8000 -> PC not incremented; vec_addr=16'hFFF2; PC=16'h8000; irq_taken one-cycle pulse.
- rst_n asserted mid INT_FETCH -> immediate PC=0, vec_req=0, busy=1; after release, fetch restarts at 16'hFFFE.
- vec_ack pulsed in RUN with vec_req=0 and pc_en=0 -> PC unchanged, no state change.
